// File: rtl/fanout_pkg.sv
// Shared types, default sizes and sizing helpers for the fanout broadcast buffer.
package fanout_pkg;

  localparam int NUM_OUT_DEFAULT    = 6;
  localparam int DATA_WIDTH_DEFAULT = 17;
  localparam int DEPTH_DEFAULT      = 2;

  typedef logic [NUM_OUT_DEFAULT-1:0]    dest_mask_t;
  typedef logic [DATA_WIDTH_DEFAULT-1:0] token_t;

  // Pointer width; a single-entry buffer still gets a 1-bit pointer that never moves.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fanout_reg_fifo.sv
// Small register-based circular buffer: push at tail, pop at head, live head output.
module fanout_reg_fifo
  import fanout_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int DEPTH      = DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_WIDTH-1:0]      push_data,
  output logic [DATA_WIDTH-1:0]      head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]         wr_ptr_reg;
  logic [PW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic [PW-1:0]         wr_ptr_next;
  logic [PW-1:0]         rd_ptr_next;
  logic                  do_push;
  logic                  do_pop;

  assign full      = (count_reg == FULL_CNT);
  assign count     = count_reg;
  assign head_data = mem_reg[rd_ptr_reg];

  // Guard the strobes so an overflow or underflow request can never corrupt state.
  assign do_push = push & ~full;
  assign do_pop  = pop & (count_reg != '0);

  // Pointers wrap modulo DEPTH so non-power-of-two depths stay in range.
  assign wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
  assign rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;

  // Pointer and occupancy tracking; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_next;
      if (do_pop)  rd_ptr_reg <= rd_ptr_next;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end

  // Token storage; entries read back as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (do_push && !flush) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

endmodule

// File: rtl/fanout_broadcast_buffer.sv
// Eager-fork broadcast buffer: each active destination takes the head once,
// and the head pops only when every active destination has taken it.
module fanout_broadcast_buffer
  import fanout_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int NUM_OUT    = NUM_OUT_DEFAULT,
  parameter int DEPTH      = DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [NUM_OUT-1:0]    dest_en,
  input  logic [NUM_OUT-1:0]    dest_sel,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]    out_valid,
  input  logic [NUM_OUT-1:0]    out_ready
);

  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       full;
  logic                       not_empty;
  logic                       complete;
  logic [NUM_OUT-1:0]         active;
  logic [NUM_OUT-1:0]         fire;
  logic [NUM_OUT-1:0]         covered;
  logic [NUM_OUT-1:0]         done_reg;
  logic [NUM_OUT-1:0]         done_next;

  fanout_reg_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (in_valid & in_ready),
    .pop       (complete),
    .push_data (in_data),
    .head_data (out_data),
    .count     (count),
    .full      (full)
  );

  // in_ready comes from registered occupancy only, so no ready path runs through.
  assign in_ready  = ~full;
  assign not_empty = (count != '0);
  assign active    = dest_en & dest_sel;

  // Per-destination handshake; a destination no longer active counts as covered.
  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_dest
    assign out_valid[gi] = not_empty & active[gi] & ~done_reg[gi];
    assign fire[gi]      = out_valid[gi] & out_ready[gi];
    assign covered[gi]   = done_reg[gi] | fire[gi] | ~active[gi];
  end

  // With no active destination every bit is covered, so the head drains as a sink.
  assign complete = not_empty & (&covered);

  // Delivery bookkeeping: clear on pop or flush, otherwise accumulate this cycle's fires.
  always_comb begin
    done_next = done_reg | fire;
    if (flush || complete) done_next = '0;
  end

  // Delivery-state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_reg <= '0;
    else        done_reg <= done_next;
  end

endmodule

// File: tb/tb_fanout_broadcast_buffer.sv
// Directed bench for fanout_broadcast_buffer with a per-destination delivery scoreboard.
module tb_fanout_broadcast_buffer;
  import fanout_pkg::*;

  localparam int NO = NUM_OUT_DEFAULT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  dest_mask_t dest_en = '0;
  dest_mask_t dest_sel = '0;
  token_t     in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  token_t     out_data;
  dest_mask_t out_valid;
  dest_mask_t out_ready = '0;

  int checks = 0;
  int errors = 0;

  token_t exp_q [NO][$];

  fanout_broadcast_buffer #(
    .DATA_WIDTH (DATA_WIDTH_DEFAULT),
    .NUM_OUT    (NUM_OUT_DEFAULT),
    .DEPTH      (DEPTH_DEFAULT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .dest_en   (dest_en),
    .dest_sel  (dest_sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Record that token d must be delivered once to every destination in mask.
  task automatic expect_token(input dest_mask_t mask, input token_t d);
    for (int i = 0; i < NO; i++) if (mask[i]) exp_q[i].push_back(d);
    $display("issue token %h to mask %b", d, mask);
  endtask

  task automatic clear_expect();
    for (int i = 0; i < NO; i++) exp_q[i].delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Monitor: every handshake must match the oldest expected token for that destination.
  always @(negedge clk) begin : monitor
    token_t e;
    if (rst_n) begin
      for (int i = 0; i < NO; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_delivery dest %0d: got %h want none", i, out_data);
          end else begin
            e = exp_q[i].pop_front();
            $display("deliver dest %0d data %h", i, out_data);
            chk($sformatf("deliver_d%0d", i), 32'(out_data), 32'(e));
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);

    // Single token to three destinations, all ready
    dest_en = 6'h3F; dest_sel = 6'b000111; out_ready = 6'h3F;
    in_valid = 1'b1; in_data = 17'h000A5;
    expect_token(6'b000111, 17'h000A5);
    settle();
    chk("t1_no_bypass", 32'(out_valid), 32'h0);
    step(); in_valid = 1'b0; settle();
    chk("t1_ov_c1", 32'(out_valid), 32'(6'b000111));
    chk("t1_ready_c1", 32'(in_ready), 32'h1);
    step(); settle();
    chk("t1_popped", 32'(out_valid), 32'h0);

    // Staggered ready
    dest_sel = 6'b000011; out_ready = '0;
    in_valid = 1'b1; in_data = 17'h000B1;
    expect_token(6'b000011, 17'h000B1);
    step(); in_valid = 1'b0; out_ready = 6'b000001; settle();
    chk("t2_ov_c1", 32'(out_valid), 32'(6'b000011));
    step(); settle();
    chk("t2_ov_c2", 32'(out_valid), 32'(6'b000010));
    step(); out_ready = 6'b000011; settle();
    chk("t2_ov_c3", 32'(out_valid), 32'(6'b000010));
    step(); settle();
    chk("t2_popped", 32'(out_valid), 32'h0);

    // Full and backpressure
    out_ready = '0;
    in_valid = 1'b1; in_data = 17'h00001;
    expect_token(6'b000011, 17'h00001);
    settle();
    chk("t3_ready_c0", 32'(in_ready), 32'h1);
    step(); in_data = 17'h00002; expect_token(6'b000011, 17'h00002); settle();
    chk("t3_ready_c1", 32'(in_ready), 32'h1);
    step(); in_data = 17'h00003; settle();
    chk("t3_full_c2", 32'(in_ready), 32'h0);
    step(); out_ready = 6'b000011; settle();
    chk("t3_full_c3", 32'(in_ready), 32'h0);
    chk("t3_ov_c3", 32'(out_valid), 32'(6'b000011));
    step(); settle();
    chk("t3_ready_after_pop", 32'(in_ready), 32'h1);
    expect_token(6'b000011, 17'h00003);
    step(); in_valid = 1'b0; settle();
    chk("t3_ov_c5", 32'(out_valid), 32'(6'b000011));
    step(); settle();
    chk("t3_drained", 32'(out_valid), 32'h0);

    // No active destination: buffer acts as a sink
    dest_sel = '0; out_ready = '0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 17'(32'h100 + k);
      settle();
      chk($sformatf("t4_ready_%0d", k), 32'(in_ready), 32'h1);
      chk($sformatf("t4_ov_%0d", k), 32'(out_valid), 32'h0);
      step();
    end
    in_valid = 1'b0; settle();
    chk("t4_ready_tail", 32'(in_ready), 32'h1);
    step(); dest_sel = 6'h3F; settle();
    chk("t4_empty", 32'(out_valid), 32'h0);

    // Mid-token deactivation of destination 5
    dest_sel = 6'b100001; out_ready = 6'b000001;
    in_valid = 1'b1; in_data = 17'h00055;
    expect_token(6'b000001, 17'h00055);
    step(); in_valid = 1'b0; settle();
    chk("t5_ov_c1", 32'(out_valid), 32'(6'b100001));
    step(); settle();
    chk("t5_ov_c2", 32'(out_valid), 32'(6'b100000));
    step(); dest_en = 6'b011111; settle();
    chk("t5_ov_deact", 32'(out_valid), 32'h0);
    step(); dest_en = 6'h3F; settle();
    chk("t5_popped", 32'(out_valid), 32'h0);

    // Async reset mid-stream with count=2 and done=000001
    dest_sel = 6'b000011; out_ready = '0;
    in_valid = 1'b1; in_data = 17'h00011;
    expect_token(6'b000011, 17'h00011);
    step(); in_data = 17'h00022; expect_token(6'b000011, 17'h00022);
    step(); in_valid = 1'b0; out_ready = 6'b000001; settle();
    chk("t6_ov_c2", 32'(out_valid), 32'(6'b000011));
    step(); out_ready = '0; settle();
    chk("t6_ov_c3", 32'(out_valid), 32'(6'b000010));
    chk("t6_full", 32'(in_ready), 32'h0);
    #1; rst_n = 1'b0; #1;
    clear_expect();
    chk("t6_rst_ov", 32'(out_valid), 32'h0);
    chk("t6_rst_ready", 32'(in_ready), 32'h1);
    step(); rst_n = 1'b1;
    step(); settle();
    chk("t6_count0_ov", 32'(out_valid), 32'h0);

    // Flush concurrent with a push
    flush = 1'b1; in_valid = 1'b1; in_data = 17'h00077;
    step(); flush = 1'b0; in_valid = 1'b0; settle();
    chk("t6_flush_ov", 32'(out_valid), 32'h0);
    chk("t6_flush_ready", 32'(in_ready), 32'h1);

    // All expected deliveries consumed
    step(); step();
    for (int i = 0; i < NO; i++) chk($sformatf("leftover_d%0d", i), 32'(exp_q[i].size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
